// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared op encodings, FSM states and requester id width for the
//             shared compare arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_SLT  = 2'b00,
    CMP_SLTU = 2'b01,
    CMP_SEQ  = 2'b10,
    CMP_SNE  = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_EXEC = 2'd1,
    CMP_RESP = 2'd2
  } cmp_state_e;

  localparam int CMP_ID_W = 1;
  typedef logic [CMP_ID_W-1:0] cmp_id_t;

endpackage
`default_nettype wire

// File: rtl/cmp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_arbiter_if
//  Purpose  : Request/response handshakes for the two requesters of the
//             shared compare datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface cmp_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  iReqValid0, iReqValid1;
  logic                  oReqReady0, oReqReady1;
  logic [1:0]            iOp0, iOp1;
  logic [DATA_WIDTH-1:0] iDataA0, iDataA1;
  logic [DATA_WIDTH-1:0] iDataB0, iDataB1;
  logic                  oRspValid0, oRspValid1;
  logic                  iRspReady0, iRspReady1;
  logic [DATA_WIDTH-1:0] oData0, oData1;

  // Arbiter side
  modport slave (
    input  iReqValid0, iReqValid1, iOp0, iOp1,
           iDataA0, iDataA1, iDataB0, iDataB1, iRspReady0, iRspReady1,
    output oReqReady0, oReqReady1, oRspValid0, oRspValid1, oData0, oData1
  );

  // Requester side
  modport master (
    output iReqValid0, iReqValid1, iOp0, iOp1,
           iDataA0, iDataA1, iDataB0, iDataB1, iRspReady0, iRspReady1,
    input  oReqReady0, oReqReady1, oRspValid0, oRspValid1, oData0, oData1
  );
endinterface
`default_nettype wire

// File: rtl/LCA.sv
`default_nettype none
// ============================================================================
//  Module   : LCA
//  Purpose  : Lookahead-carry adder, sum = a + b + ci with carry-out.
//  Revision : 1.0 - initial release
// ============================================================================
module LCA #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  // Carries from per-bit generate/propagate terms
  always_comb begin
    w_g    = a_i & b_i;
    w_p    = a_i ^ b_i;
    w_c    = '0;
    w_c[0] = ci_i;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum_o = w_p ^ w_c[WIDTH-1:0];
  assign co_o  = w_c[WIDTH];
endmodule
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_core
//  Purpose  : Combinational SLT/SLTU/SEQ/SNE from a single A - B subtraction.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_core
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  cmp_op_e               op_i,
  output logic                  res_o
);
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_cout;
  logic                  w_ovf;
  logic                  w_slt;
  logic                  w_sltu;
  logic                  w_zero;

  // A - B as A + ~B + 1
  LCA #(.WIDTH(DATA_WIDTH)) u_lca (
    .a_i   (a_i),
    .b_i   (~b_i),
    .ci_i  (1'b1),
    .sum_o (w_diff),
    .co_o  (w_cout)
  );

  assign w_ovf  = ( a_i[DATA_WIDTH-1] & ~b_i[DATA_WIDTH-1] & ~w_diff[DATA_WIDTH-1]) |
                  (~a_i[DATA_WIDTH-1] &  b_i[DATA_WIDTH-1] &  w_diff[DATA_WIDTH-1]);
  assign w_slt  = w_diff[DATA_WIDTH-1] ^ w_ovf;
  assign w_sltu = ~w_cout;              // a borrow means A < B unsigned
  assign w_zero = (w_diff == '0);

  // Select the flag requested by the op
  always_comb begin
    res_o = 1'b0;
    case (op_i)
      CMP_SLT:  res_o = w_slt;
      CMP_SLTU: res_o = w_sltu;
      CMP_SEQ:  res_o = w_zero;
      CMP_SNE:  res_o = ~w_zero;
      default:  res_o = 1'b0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_arbiter
//  Purpose  : Round-robin share of one compare datapath between two
//             requesters; one operation in flight, held response.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic               iClk,
  input  logic               iRst,
  cmp_arbiter_if.slave       bus_if
);
  cmp_state_e            state_q, state_d;
  logic                  prio_q, prio_d;
  cmp_id_t               id_q;
  cmp_op_e               op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;

  logic                  w_any_req;
  cmp_id_t               w_gnt_id;
  logic                  w_rsp_hs;
  logic                  w_cmp_res;

  // Both valid: pointer wins; otherwise the lone valid requester wins
  assign w_any_req = bus_if.iReqValid0 | bus_if.iReqValid1;
  assign w_gnt_id  = (bus_if.iReqValid0 & bus_if.iReqValid1) ? prio_q : bus_if.iReqValid1;
  assign w_rsp_hs  = (id_q == 1'b0) ? bus_if.iRspReady0 : bus_if.iRspReady1;

  cmp_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (w_cmp_res)
  );

  // State and round-robin pointer registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= CMP_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next state, pointer update and handshake outputs
  always_comb begin
    state_d           = state_q;
    prio_d            = prio_q;
    bus_if.oReqReady0 = 1'b0;
    bus_if.oReqReady1 = 1'b0;
    bus_if.oRspValid0 = 1'b0;
    bus_if.oRspValid1 = 1'b0;
    case (state_q)
      CMP_IDLE: begin
        bus_if.oReqReady0 = bus_if.iReqValid0 & (w_gnt_id == 1'b0);
        bus_if.oReqReady1 = bus_if.iReqValid1 & (w_gnt_id == 1'b1);
        if (w_any_req) begin
          state_d = CMP_EXEC;
          prio_d  = ~w_gnt_id;
        end
      end
      CMP_EXEC: state_d = CMP_RESP;
      CMP_RESP: begin
        bus_if.oRspValid0 = (id_q == 1'b0);
        bus_if.oRspValid1 = (id_q == 1'b1);
        if (w_rsp_hs) state_d = CMP_IDLE;
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  // Capture the granted request on its handshake
  always_ff @(posedge iClk) begin
    if (iRst) begin
      id_q <= '0;
      op_q <= CMP_SLT;
      a_q  <= '0;
      b_q  <= '0;
    end else if ((state_q == CMP_IDLE) && w_any_req) begin
      id_q <= w_gnt_id;
      op_q <= cmp_op_e'(w_gnt_id ? bus_if.iOp1 : bus_if.iOp0);
      a_q  <= w_gnt_id ? bus_if.iDataA1 : bus_if.iDataA0;
      b_q  <= w_gnt_id ? bus_if.iDataB1 : bus_if.iDataB0;
    end
  end

  // Register the compare result into the owner's response; the other holds
  always_ff @(posedge iClk) begin
    if (iRst) begin
      data0_q <= '0;
      data1_q <= '0;
    end else if (state_q == CMP_EXEC) begin
      if (id_q == 1'b0) data0_q <= {{(DATA_WIDTH-1){1'b0}}, w_cmp_res};
      else              data1_q <= {{(DATA_WIDTH-1){1'b0}}, w_cmp_res};
    end
  end

  assign bus_if.oData0 = data0_q;
  assign bus_if.oData1 = data1_q;
endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_arbiter
//  Purpose  : Directed self-checking bench for cmp_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vectors     = 0;
  int   n_miscompares = 0;

  always #5 clk = ~clk;

  cmp_arbiter_if #(.DATA_WIDTH(32)) bus ();

  cmp_arbiter #(.DATA_WIDTH(32)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .bus_if (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t       vecs [8];
  logic [1:0] exp_gnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_req(input int r, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      bus.iReqValid0 = v; bus.iOp0 = op; bus.iDataA0 = a; bus.iDataB0 = b;
    end else begin
      bus.iReqValid1 = v; bus.iOp1 = op; bus.iDataA1 = a; bus.iDataB1 = b;
    end
  endtask

  task automatic set_rsp_ready(input int r, input logic v);
    if (r == 0) bus.iRspReady0 = v;
    else        bus.iRspReady1 = v;
  endtask

  function automatic logic [31:0] rd_data(input int r);
    return (r == 0) ? bus.oData0 : bus.oData1;
  endfunction

  function automatic logic [31:0] rd_rdy();
    return {30'b0, bus.oReqReady1, bus.oReqReady0};
  endfunction

  function automatic logic [31:0] rd_rsp();
    return {30'b0, bus.oRspValid1, bus.oRspValid0};
  endfunction

  // Single operation from requester r; entered and left #1 after a posedge
  task automatic run_op(input int r, input vec_t v);
    logic [31:0] one_hot;
    one_hot = (r == 0) ? 32'd1 : 32'd2;
    drive_req(r, 1'b1, v.op, v.a, v.b);
    @(negedge clk); chk({v.tag, "_rdy"}, rd_rdy(), one_hot);
    @(posedge clk); #1 drive_req(r, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk); chk({v.tag, "_exec_rsp"}, rd_rsp(), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk({v.tag, "_rsp"}, rd_rsp(), one_hot);
                    chk({v.tag, "_data"}, rd_data(r), v.exp);
    set_rsp_ready(r, 1'b1);
    @(posedge clk); #1 set_rsp_ready(r, 1'b0);
  endtask

  initial begin
    vecs[0] = '{CMP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1, "slt_neg"};
    vecs[1] = '{CMP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, "sltu_big"};
    vecs[2] = '{CMP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1, "slt_ovf0"};
    vecs[3] = '{CMP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, "slt_ovf1"};
    vecs[4] = '{CMP_SLTU, 32'h0000_0000, 32'hFFFF_FFFF, 32'd1, "sltu_zero"};
    vecs[5] = '{CMP_SEQ,  32'h1234_5678, 32'h1234_5678, 32'd1, "seq_eq"};
    vecs[6] = '{CMP_SNE,  32'h1234_5678, 32'h1234_5678, 32'd0, "sne_eq"};
    vecs[7] = '{CMP_SEQ,  32'h0000_0000, 32'h8000_0000, 32'd0, "seq_ne"};
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};

    drive_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    bus.iRspReady0 = 1'b0;
    bus.iRspReady1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", rd_rdy(), 32'd0);
    chk("rst_rsp", rd_rsp(), 32'd0);
    chk("rst_data0", bus.oData0, 32'd0);
    chk("rst_data1", bus.oData1, 32'd0);
    @(posedge clk); #1;

    // Arbitration: both valid continuously, strict alternation from 0
    drive_req(0, 1'b1, CMP_SEQ,  32'd7, 32'd7);
    drive_req(1, 1'b1, CMP_SLTU, 32'd1, 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("arb_gnt", rd_rdy(), {30'b0, exp_gnt[k]});
      @(negedge clk); chk("arb_exec_rdy", rd_rdy(), 32'd0);
      @(negedge clk); chk("arb_rsp_route", rd_rsp(), {30'b0, exp_gnt[k]});
                      chk("arb_data", rd_data(k % 2), 32'd1);
      bus.iRspReady0 = 1'b1;
      bus.iRspReady1 = 1'b1;
      @(posedge clk); #1;
      bus.iRspReady0 = 1'b0;
      bus.iRspReady1 = 1'b0;
    end
    drive_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_req(1, 1'b0, 2'b00, 32'h0, 32'h0);

    // Compare functions and corners
    for (int i = 0; i < 8; i++) run_op(0, vecs[i]);

    // Backpressure on requester 0 while requester 1 waits
    drive_req(0, 1'b1, CMP_SLT, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk); chk("bp_rdy0", rd_rdy(), 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_req(1, 1'b1, CMP_SLT, 32'd5, 32'd3);
    @(negedge clk); chk("bp_exec_rdy1", rd_rdy(), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_rsp", rd_rsp(), 32'd1);
      chk("bp_data0", bus.oData0, 32'd1);
      chk("bp_rdy1", rd_rdy(), 32'd0);
    end
    bus.iRspReady0 = 1'b1;
    chk("bp_rel_rdy1", rd_rdy(), 32'd0);
    @(posedge clk); #1 bus.iRspReady0 = 1'b0;
    @(negedge clk); chk("bp_after_rdy1", rd_rdy(), 32'd2);
    @(posedge clk); #1 drive_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk); chk("bp_exec1", rd_rsp(), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rsp1", rd_rsp(), 32'd2);
                    chk("bp_data1", bus.oData1, 32'd0);
                    chk("bp_hold0", bus.oData0, 32'd1);
    bus.iRspReady1 = 1'b1;
    @(posedge clk); #1 bus.iRspReady1 = 1'b0;

    // Reset during EXEC after a req0 handshake moved the pointer to 1
    drive_req(0, 1'b1, CMP_SLT, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk); chk("mr_rdy0", rd_rdy(), 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_rdy", rd_rdy(), 32'd0);
    chk("mr_data0", bus.oData0, 32'd0);
    chk("mr_data1", bus.oData1, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("mr_no_rsp", rd_rsp(), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b1, CMP_SEQ, 32'd1, 32'd1);
    drive_req(1, 1'b1, CMP_SEQ, 32'd1, 32'd1);
    @(negedge clk); chk("mr_prio", rd_rdy(), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
`default_nettype wire
